alu_seq: RTL and testbench

//   Parametrised sequential ALU, successor to the 8-bit combinational ALU.

---
 rtl/alu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags and a start/ready/done handshake.
// Single-cycle ops finish one edge after accept; shifts and MUL iterate one step per cycle.
module alu_seq #(
   parameter int unsigned WIDTH  = 8,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       fn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             fz,
   output logic             fc,
   output logic             fneg,
   output logic             fv,
   output logic             err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] MULT  = 2'd2;

   localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam int unsigned      MSB  = WIDTH - 1;

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-1:0]   work_q, work_d;
   logic               sc_q, sc_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               pend_q, pend_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               fz_q, fz_d, fc_q, fc_d, fneg_q, fneg_d, fv_q, fv_d;
   logic               done_q, err_q, err_d;

   logic               accept, fn_shift, fn_mul, cin, legal, c, v;
   logic [WIDTH-1:0]   n_sh, r;
   logic [WIDTH:0]     mul_sum, add_w, sub_w;

   assign ready    = (state_q == IDLE);
   assign accept   = start && ready;
   assign fn_shift = (fn == 4'h7) || (fn == 4'h8) || (fn == 4'h9);
   assign fn_mul   = MUL_EN && (fn == 4'hA);
   assign n_sh     = (a >= WMAX) ? WMAX : a;

   // Shift-add multiplier: upper half accumulates, lower half holds the remaining multiplier bits.
   assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);

   assign cin   = op_q[0] & fc_q;
   assign add_w = {1'b0, b_q} + {1'b0, a_q} + {{WIDTH{1'b0}}, cin};
   assign sub_w = {1'b0, b_q} - {1'b0, a_q} - {{WIDTH{1'b0}}, cin};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      sc_d    = sc_q;
      prod_d  = prod_q;
      pend_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               work_d = b;
               sc_d   = 1'b0;
               prod_d = {{WIDTH{1'b0}}, a};
               if (fn_shift && (n_sh != '0)) begin
                  state_d = SHIFT;
                  cnt_d   = n_sh;
               end else if (fn_mul) begin
                  state_d = MULT;
                  cnt_d   = WMAX;
               end else begin
                  pend_d = 1'b1;
               end
            end
         end
         SHIFT, MULT: begin
            if (state_q == SHIFT) begin
               case (op_q)
                  4'h7: begin
                     sc_d   = work_q[MSB];
                     work_d = {work_q[WIDTH-2:0], 1'b0};
                  end
                  4'h8: begin
                     sc_d   = work_q[0];
                     work_d = {1'b0, work_q[WIDTH-1:1]};
                  end
                  default: begin
                     sc_d   = work_q[0];
                     work_d = {work_q[MSB], work_q[WIDTH-1:1]};
                  end
               endcase
            end else begin
               prod_d = {mul_sum, prod_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
               state_d = IDLE;
               pend_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      r     = '0;
      c     = 1'b0;
      v     = 1'b0;
      legal = 1'b1;
      case (op_q)
         4'h0, 4'h1: begin
            r = add_w[WIDTH-1:0];
            c = add_w[WIDTH];
            v = (b_q[MSB] == a_q[MSB]) && (r[MSB] != b_q[MSB]);
         end
         4'h2, 4'h3: begin
            r = sub_w[WIDTH-1:0];
            c = sub_w[WIDTH];
            v = (b_q[MSB] != a_q[MSB]) && (r[MSB] != b_q[MSB]);
         end
         4'h4: r = b_q & a_q;
         4'h5: r = b_q | a_q;
         4'h6: r = b_q ^ a_q;
         4'h7, 4'h8, 4'h9: begin
            r = work_q;
            c = sc_q;
         end
         4'hA: begin
            if (MUL_EN) begin
               r = prod_q[WIDTH-1:0];
               c = |prod_q[2*WIDTH-1:WIDTH];
            end else begin
               legal = 1'b0;
            end
         end
         default: legal = 1'b0;
      endcase

      res_d  = res_q;
      fz_d   = fz_q;
      fc_d   = fc_q;
      fneg_d = fneg_q;
      fv_d   = fv_q;
      err_d  = 1'b0;
      if (pend_q) begin
         if (legal) begin
            res_d  = r;
            fz_d   = (r == '0);
            fc_d   = c;
            fneg_d = r[MSB];
            fv_d   = v;
         end else begin
            res_d = b_q;
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sc_q    <= 1'b0;
         prod_q  <= '0;
         pend_q  <= 1'b0;
         res_q   <= '0;
         fz_q    <= 1'b0;
         fc_q    <= 1'b0;
         fneg_q  <= 1'b0;
         fv_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         sc_q    <= sc_d;
         prod_q  <= prod_d;
         pend_q  <= pend_d;
         res_q   <= res_d;
         fz_q    <= fz_d;
         fc_q    <= fc_d;
         fneg_q  <= fneg_d;
         fv_q    <= fv_d;
         done_q  <= pend_q;
         err_q   <= err_d;
         if (accept) begin
            op_q <= fn;
            a_q  <= a;
            b_q  <= b;
         end
      end
   end

   assign done = done_q;
   assign res  = res_q;
   assign fz   = fz_q;
   assign fc   = fc_q;
   assign fneg = fneg_q;
   assign fv   = fv_q;
   assign err  = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: issued ops push expected results, a monitor checks each done.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] fn = '0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       ready, done, fz, fc, fneg, fv, err;
   logic [7:0] res;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      string      name;
      logic [7:0] res;
      logic [4:0] fl;   // {fz, fc, fneg, fv, err}
      int         cyc;
   } exp_t;

   exp_t q[$];

   alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .fn    (fn),
      .a     (a),
      .b     (b),
      .ready (ready),
      .done  (done),
      .res   (res),
      .fz    (fz),
      .fc    (fc),
      .fneg  (fneg),
      .fv    (fv),
      .err   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, expv);
   endtask

   // Waits for ready, presents one request across a single edge, optionally scoreboards it.
   task automatic issue(input string nm, input logic [3:0] f, input logic [7:0] av,
                        input logic [7:0] bv, input int lat, input logic [7:0] er,
                        input logic [4:0] efl, input bit push);
      int w = 0;
      exp_t e;
      @(negedge clk);
      while (!ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!ready) check({nm, "_ready_wait"}, ready, 1);
      start = 1'b1;
      fn    = f;
      a     = av;
      b     = bv;
      if (push) begin
         e.name = nm;
         e.res  = er;
         e.fl   = efl;
         e.cyc  = cyc + 1 + lat;
         q.push_back(e);
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check(e.name, {res, fz, fc, fneg, fv, err}, {e.res, e.fl});
            check({e.name, "_latency"}, cyc, e.cyc);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", {res, fz, fc, fneg, fv, done, err, ready}, {8'h00, 7'b0000001});
      rst = 1'b0;

      //           name      fn    a      b      L  res    {fz,fc,fneg,fv,err}
      issue("add_ff_01",  4'h0, 8'h01, 8'hFF, 1, 8'h00, 5'b11000, 1);
      issue("adc_b2b",    4'h1, 8'h00, 8'h00, 1, 8'h01, 5'b00000, 1);
      issue("sub_01_02",  4'h2, 8'h02, 8'h01, 1, 8'hFF, 5'b01100, 1);
      issue("sub_ovf",    4'h2, 8'h80, 8'h00, 1, 8'h80, 5'b01110, 1);
      issue("sbc_borrow", 4'h3, 8'h00, 8'h05, 1, 8'h04, 5'b00000, 1);
      issue("and",        4'h4, 8'hF0, 8'h3C, 1, 8'h30, 5'b00000, 1);
      issue("or",         4'h5, 8'h0F, 8'h30, 1, 8'h3F, 5'b00000, 1);
      issue("xor",        4'h6, 8'hFF, 8'h0F, 1, 8'hF0, 5'b00100, 1);
      issue("add_ovf",    4'h0, 8'h7F, 8'h01, 1, 8'h80, 5'b00110, 1);

      issue("lsl_2",      4'h7, 8'h02, 8'h0C, 3, 8'h30, 5'b00000, 1);
      @(negedge clk) check("lsl_busy_0", ready, 0);
      @(negedge clk) check("lsl_busy_1", ready, 0);
      @(negedge clk) check("lsl_ready_back", ready, 1);

      issue("lsr_1",      4'h8, 8'h01, 8'h03, 2, 8'h01, 5'b01000, 1);
      issue("asr_9",      4'h9, 8'h09, 8'h80, 9, 8'hFF, 5'b01100, 1);
      issue("lsl_0",      4'h7, 8'h00, 8'hA5, 1, 8'hA5, 5'b00100, 1);
      issue("lsr_8",      4'h8, 8'h08, 8'hFF, 9, 8'h00, 5'b11000, 1);

      issue("mul_10_10",  4'hA, 8'h10, 8'h10, 9, 8'h00, 5'b11000, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b1;
         fn    = 4'h0;
         a     = 8'h11;
         b     = 8'h22;
         check("mul_busy_ignore", ready, 0);
      end
      @(negedge clk) start = 1'b0;
      issue("mul_0d_0b",  4'hA, 8'h0D, 8'h0B, 9, 8'h8F, 5'b00100, 1);
      issue("illegal_b",  4'hB, 8'h12, 8'h34, 1, 8'h34, 5'b00101, 1);

      // Abort a multiply in flight; it must never complete.
      issue("mul_abort",  4'hA, 8'h03, 8'h05, 9, 8'h0F, 5'b00000, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_mul", {res, fz, fc, fneg, fv, done, err, ready}, {8'h00, 7'b0000001});
      repeat (12) @(negedge clk);

      issue("illegal_f",  4'hF, 8'h00, 8'h5A, 1, 8'h5A, 5'b00001, 1);

      begin
         int w = 0;
         while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
         end
         check("queue_drained", q.size(), 0);
      end
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
